md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline; sits beside the E-stage ALU.
//  - Accepts mult/multu/div/divu from E.
//  - Owns the HI/LO registers and services mthi/mtlo/mfhi/mflo.
//  - Models fixed operation latency with a busy counter.
//  - Raises a stall request toward the hazard unit while a D-stage md-class instruction must wait.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
//  CNT_W        4   counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high
//  e_start    in   1   E-stage md arithmetic instruction valid this cycle
//  e_op       in   2   00 mult, 01 multu, 10 div, 11 divu
//  e_a        in   32  rs operand (forwarded)
//  e_b        in   32  rt operand (forwarded)
//  e_mthi     in   1   E-stage mthi: HI <= e_a
//  e_mtlo     in   1   E-stage mtlo: LO <= e_a
//  e_rd_hi    in   1   mfhi select for md_out (else LO)
//  d_is_md    in   1   D-stage instr is mult/div/mthi/mtlo/mfhi/mflo
//  md_out     out  32  HI or LO, combinational from e_rd_hi
//  busy       out  1   operation in flight (registered)
//  stall_req  out  1   d_is_md & (e_start | busy), combinational
//  hi         out  32  HI register (debug/visibility)
//  lo         out  32  LO register (debug/visibility)
// BEHAVIOUR
//  Reset: state IDLE, cnt=0, busy=0, HI=0, LO=0, pending result=0. Reset mid-operation aborts it;
//   the result is discarded.
//  FSM, two states:
//  - IDLE: on e_start, compute result into pend_hi/pend_lo, load cnt with N (op-dependent), busy<=1, go RUN.
//  - RUN: cnt<=cnt-1 each cycle. When cnt==1: HI<=pend_hi, LO<=pend_lo, busy<=0, cnt<=0, go IDLE.
//  Latency: with start in cycle T, busy is high T+1..T+N; the new HI/LO is visible from cycle T+N+1.
//  Arithmetic:
//  - mult: signed 32x32->64, HI=upper 32 bits, LO=lower 32 bits. multu: the same, unsigned.
//  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
//    0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
//  - divu: unsigned.
//  - Divide by zero: the op still runs N cycles; HI/LO keep their previous values at completion.
//  mthi/mtlo:
//  - Take effect at the clock edge when IDLE and not e_start.
//  - If asserted while busy or with e_start: ignored. The hazard unit guarantees this cannot happen;
//    the bench flags it as an error.
//  - mthi and mtlo in the same cycle: both write.
//  e_start while busy: ignored (no restart); the bench flags it as an error.
//  md_out reads the current HI/LO. A read during busy returns the pre-operation value; the stall
//   prevents that use.
//  Back-to-back: start may be accepted in the cycle after completion (busy already 0).
// STRUCTURE
//  - Shared package (md_pkg): MD_MULT/MD_MULTU/MD_DIV/MD_DIVU encodings; the IDLE/RUN state encoding.
//    The CONTROL decoder emits e_op from the same constants.
//  - Sub-module md_calc: purely combinational 64-bit result from (op, a, b), including the div-by-zero
//    hold flag.
//  - md_sequencer holds the FSM, counter, pending registers and HI/LO.
// TESTING
//  1. mult a=0xFFFFFFFF b=2 -> busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//     multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
//  2. div a=-7 (0xFFFFFFF9) b=2 -> busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//     divu 7/2 -> LO=3, HI=1.
//  3. div by 0 with HI=0x11, LO=0x22 preset via mthi/mtlo -> after 10 cycles HI=0x11, LO=0x22,
//     busy drops on time.
//  4. mult start at T with d_is_md=1 -> stall_req=1 for T..T+5, 0 at T+6;
//     with d_is_md=0, stall_req stays 0 throughout.
//  5. reset asserted at cycle 3 of a div -> next cycle busy=0, HI=LO=0;
//     a new mult starting after reset completes normally.
//  6. e_start asserted again while busy, and mtlo asserted while busy -> both ignored,
//     the original result lands at T+N, and the bench error counter increments.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// The CONTROL decoder emits e_op from the same MD_* constants, so the two
// sides cannot drift apart.
package md_pkg;

    // e_op encodings; bit 1 separates divide from multiply and
    // bit 0 selects the unsigned flavour.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Sequencer state encoding, kept as plain constants so the legacy
    // hazard/debug logic can compare against raw bits.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Readable view of the op field.
    typedef enum logic [1:0] {
        OP_MULT  = MD_MULT,
        OP_MULTU = MD_MULTU,
        OP_DIV   = MD_DIV,
        OP_DIVU  = MD_DIVU
    } md_op_e;

    // Combinational result of one operation. hold is set for a divide by
    // zero: the sequence still runs, but HI/LO are left untouched.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        hold;
    } md_res_t;

    // Divide vs. multiply.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed flavour (mult/div) vs. unsigned (multu/divu).
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E/D-stage interface of the multiply/divide sequencer.
// master: the pipeline side (E and D stages plus hazard unit).
// slave:  the sequencer itself.
interface md_sequencer_if;

    logic        e_start;    // md arithmetic instruction in E this cycle
    logic [1:0]  e_op;       // MD_* encoding
    logic [31:0] e_a;        // rs operand, already forwarded
    logic [31:0] e_b;        // rt operand, already forwarded
    logic        e_mthi;     // HI <= e_a
    logic        e_mtlo;     // LO <= e_a
    logic        e_rd_hi;    // md_out selects HI when set, else LO
    logic        d_is_md;    // D-stage instruction touches HI/LO or the unit

    logic [31:0] md_out;     // mfhi/mflo data
    logic        busy;       // operation in flight
    logic        stall_req;  // hold the D-stage md instruction
    logic [31:0] hi;         // HI register, for visibility
    logic [31:0] lo;         // LO register, for visibility

    modport master (
        output e_start, e_op, e_a, e_b, e_mthi, e_mtlo, e_rd_hi, d_is_md,
        input  md_out, busy, stall_req, hi, lo
    );

    modport slave (
        input  e_start, e_op, e_a, e_b, e_mthi, e_mtlo, e_rd_hi, d_is_md,
        output md_out, busy, stall_req, hi, lo
    );

endinterface

// File: rtl/md_calc.sv
// Purely combinational 32x32 multiply / divide datapath.
// Divides run on magnitudes and fix the signs afterwards, which makes
// 0x80000000 / -1 come out as 0x80000000 rem 0 without relying on how a
// tool treats signed overflow.
module md_calc
    import md_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output md_res_t     res
);

    logic        sx;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
    // extended product are the exact signed/unsigned result.
    always_comb begin
        sx    = md_is_signed(op);
        ext_a = {{32{sx & a[31]}}, a};
        ext_b = {{32{sx & b[31]}}, b};
        prod  = ext_a * ext_b;
    end

    // Divide: magnitude division, quotient negated when the signs differ,
    // remainder takes the sign of the dividend. A zero divisor is replaced
    // by 1 only to keep the divider defined; the result is discarded.
    always_comb begin
        a_neg    = md_is_signed(op) & a[31];
        b_neg    = md_is_signed(op) & b[31];
        a_mag    = a_neg ? (~a + 32'd1) : a;
        b_mag    = b_neg ? (~b + 32'd1) : b;
        div_zero = (b == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Result select.
    always_comb begin
        res = '0;
        if (md_is_div(op)) begin
            res.hi   = rem;
            res.lo   = quot;
            res.hold = div_zero;
        end else begin
            res.hi   = prod[63:32];
            res.lo   = prod[31:0];
            res.hold = 1'b0;
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer beside the E-stage ALU.
// The result is computed combinationally at start and parked in pend_*;
// a busy counter models the unit latency, and HI/LO are committed on the
// last busy cycle so the new values are visible from T+N+1.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_hold;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    md_res_t          calc_res;
    logic             accept;
    logic             complete;
    logic             mt_ok;

    md_calc u_calc (
        .op  (bus.e_op),
        .a   (bus.e_a),
        .b   (bus.e_b),
        .res (calc_res)
    );

    // Start only from IDLE; a start while busy is dropped. Moves to HI/LO
    // only land in a quiet IDLE cycle so they can never race a commit.
    always_comb begin
        accept   = (state == ST_IDLE) && bus.e_start;
        complete = (state == ST_RUN) && (cnt == CNT_1);
        mt_ok    = (state == ST_IDLE) && !bus.e_start;
    end

    // FSM, latency counter and pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy_q    <= 1'b0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_hold <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pend_hi   <= calc_res.hi;
                        pend_lo   <= calc_res.lo;
                        pend_hold <= calc_res.hold;
                        cnt       <= md_is_div(bus.e_op) ? DIV_N : MULT_N;
                        busy_q    <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (complete) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // HI/LO: commit on the last busy cycle unless the op was a divide by
    // zero; otherwise accept mthi/mtlo (both may write in one cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (complete) begin
            if (!pend_hold) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else if (mt_ok) begin
            if (bus.e_mthi) hi_q <= bus.e_a;
            if (bus.e_mtlo) lo_q <= bus.e_a;
        end
    end

    // Outputs: md_out reads current HI/LO, so a read during busy still sees
    // the pre-operation value; the stall keeps the D stage from using it.
    always_comb begin
        bus.md_out    = bus.e_rd_hi ? hi_q : lo_q;
        bus.busy      = busy_q;
        bus.stall_req = bus.d_is_md & (bus.e_start | busy_q);
        bus.hi        = hi_q;
        bus.lo        = lo_q;
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: a vector table of operations run through a
// scoreboard, plus hand sequences for mthi/mtlo, div-by-zero, stall,
// reset abort and protocol violations.
module tb_md_sequencer;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_sequencer_if bus();

    md_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          proto_errs = 0;
    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    vec_t        vecs[10];

    // Protocol monitor: anything issued to a busy unit, or a move together
    // with a start, is a hazard-unit error.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy && bus.e_start) proto_errs++;
            if (bus.busy && (bus.e_mthi || bus.e_mtlo)) proto_errs++;
            if (!bus.busy && bus.e_start && (bus.e_mthi || bus.e_mtlo)) proto_errs++;
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.e_start = 1'b0;
        bus.e_mthi  = 1'b0;
        bus.e_mtlo  = 1'b0;
    endtask

    function automatic int op_cycles(input logic [1:0] op);
        return op[1] ? 10 : 5;
    endfunction

    // Check a completed op against the head of the scoreboard.
    task automatic retire(input string tag, input int busy_cnt);
        exp_t e;
        if (sb.size() == 0) begin
            chki({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chki({tag, "_busy_cycles"}, busy_cnt, e.cycles);
        chk32({tag, "_hi"}, bus.hi, e.hi);
        chk32({tag, "_lo"}, bus.lo, e.lo);
        bus.e_rd_hi = 1'b1;
        #1;
        chk32({tag, "_mfhi"}, bus.md_out, e.hi);
        bus.e_rd_hi = 1'b0;
        #1;
        chk32({tag, "_mflo"}, bus.md_out, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // Issue one op, follow it to completion, check latency, stall and result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic d_md);
        int stall_cnt = 0;
        int busy_cnt = 0;
        int early = 0;
        sb.push_back('{hi: exp_hi, lo: exp_lo, cycles: op_cycles(op)});
        bus.e_op    = op;
        bus.e_a     = a;
        bus.e_b     = b;
        bus.e_start = 1'b1;
        bus.d_is_md = d_md;
        #1;
        if (bus.stall_req) stall_cnt++;
        tick();
        bus.e_start = 1'b0;
        #1;
        while (bus.busy && busy_cnt < 64) begin
            busy_cnt++;
            if (bus.stall_req) stall_cnt++;
            if (bus.hi !== m_hi || bus.lo !== m_lo) early++;
            tick();
            #1;
        end
        chki({tag, "_early_update"}, early, 0);
        chki({tag, "_stall_cycles"}, stall_cnt, d_md ? op_cycles(op) + 1 : 0);
        chki({tag, "_stall_after"}, int'(bus.stall_req), 0);
        retire(tag, busy_cnt);
        bus.d_is_md = 1'b0;
    endtask

    initial begin
        vecs[0] = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6] = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[7] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[8] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        reset       = 1'b1;
        bus.e_op    = MD_MULT;
        bus.e_a     = '0;
        bus.e_b     = '0;
        bus.e_rd_hi = 1'b0;
        bus.d_is_md = 1'b1;
        clear_inputs();
        tick();
        tick();
        // Reset state; stall must stay low with a D-stage md instruction.
        chki("rst_busy", int'(bus.busy), 0);
        chk32("rst_hi", bus.hi, 32'h0);
        chk32("rst_lo", bus.lo, 32'h0);
        chki("rst_stall", int'(bus.stall_req), 0);
        reset       = 1'b0;
        bus.d_is_md = 1'b0;
        tick();

        // Stall shape: with a D-stage md instruction, then without.
        run_op("stall_md", MD_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        run_op("stall_nomd", MD_MULT, 32'h3, 32'h5, 32'h0, 32'hF, 1'b0);

        // Table vectors, issued back to back.
        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);

        // mthi and mtlo in the same cycle both write.
        bus.e_a    = 32'h55;
        bus.e_mthi = 1'b1;
        bus.e_mtlo = 1'b1;
        tick();
        clear_inputs();
        chk32("mt_both_hi", bus.hi, 32'h55);
        chk32("mt_both_lo", bus.lo, 32'h55);

        // Preset HI/LO, then divide by zero must leave them alone.
        bus.e_a    = 32'h11;
        bus.e_mthi = 1'b1;
        tick();
        clear_inputs();
        bus.e_a    = 32'h22;
        bus.e_mtlo = 1'b1;
        tick();
        clear_inputs();
        chk32("mthi", bus.hi, 32'h11);
        chk32("mtlo", bus.lo, 32'h22);
        m_hi = 32'h11;
        m_lo = 32'h22;
        run_op("div0", MD_DIV, 32'h1234, 32'h0, 32'h11, 32'h22, 1'b1);

        // Reset during the third busy cycle of a divide aborts it.
        bus.e_op    = MD_DIV;
        bus.e_a     = 32'd100;
        bus.e_b     = 32'd7;
        bus.e_start = 1'b1;
        tick();
        bus.e_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chki("abort_busy", int'(bus.busy), 0);
        chk32("abort_hi", bus.hi, 32'h0);
        chk32("abort_lo", bus.lo, 32'h0);
        m_hi = '0;
        m_lo = '0;
        run_op("post_rst", MD_MULT, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0);

        // Start and mtlo while busy are ignored; the original result lands.
        begin
            int n = 0;
            sb.push_back('{hi: 32'h0, lo: 32'd42, cycles: 5});
            bus.e_op    = MD_MULTU;
            bus.e_a     = 32'd6;
            bus.e_b     = 32'd7;
            bus.e_start = 1'b1;
            tick();
            clear_inputs();
            #1;
            while (bus.busy && n < 64) begin
                n++;
                if (n == 2) begin
                    bus.e_op    = MD_DIV;
                    bus.e_a     = 32'd100;
                    bus.e_b     = 32'd3;
                    bus.e_start = 1'b1;
                    bus.e_mtlo  = 1'b1;
                end else begin
                    clear_inputs();
                end
                tick();
                #1;
            end
            clear_inputs();
            retire("ignore", n);
            chki("proto_errs", proto_errs, 2);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
